// File: rtl/keypad_matrix_emulator.sv
// keypad_matrix_emulator
// Emulates one key of a 4x4 active-high keypad matrix for exercising a keypad
// scanner. A requested key is "pressed" with an optional contact-bounce burst,
// held (row output follows the latched column drive), then "released" with an
// optional bounce burst. Completed scans of the key column are counted in HELD.
//
// Build option: define KEYPAD_EMU_BOUNCE_EN to generate the bounce bursts.
// Without it the bounce states are skipped, contact steps once, and the bounce
// parameters are accepted but unused.
module keypad_matrix_emulator #(
    parameter int BOUNCE_CYCLES = 8,
    parameter int BOUNCE_EDGES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col,
    output logic [3:0] fila,
    input  logic [3:0] key_id,
    input  logic       press_req,
    input  logic       release_req,
    output logic       busy,
    output logic       held,
    output logic [7:0] scans
);

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        PRESS_BOUNCE   = 2'd1,
        HELD           = 2'd2,
        RELEASE_BOUNCE = 2'd3
    } state_t;

    state_t     state_reg;
    logic       contact_reg;
    logic       busy_reg;
    logic       held_reg;
    logic       col_prev_reg;
    logic [3:0] key_reg;
    logic [7:0] scans_reg;

    logic       col_hit;
    logic       scan_edge;

    // Out-of-range parameters have no dedicated handling; this block only names the legal range.
    if (BOUNCE_CYCLES < 1 || BOUNCE_CYCLES > 255 || BOUNCE_EDGES < 1 || BOUNCE_EDGES > 15) begin : g_params_out_of_range
    end

    // Only the latched column is ever examined; other col bits are don't-care.
    assign col_hit   = col[key_reg[1:0]];
    assign scan_edge = col_hit & ~col_prev_reg;

`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam int TIMER_W = $clog2(BOUNCE_CYCLES + 1);
    localparam int EDGE_W  = $clog2(BOUNCE_EDGES + 1);

    logic [TIMER_W-1:0] timer_reg;
    logic [EDGE_W-1:0]  edges_reg;
    logic               phase_done;
    logic               last_edge;

    // A bounce phase lasts BOUNCE_CYCLES clocks; the burst ends on toggle number BOUNCE_EDGES.
    assign phase_done = (timer_reg == TIMER_W'(BOUNCE_CYCLES - 1));
    assign last_edge  = (edges_reg == EDGE_W'(BOUNCE_EDGES - 1));
`endif

    // Main FSM: state, contact, latched key, scan counter and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            contact_reg  <= 1'b0;
            busy_reg     <= 1'b0;
            held_reg     <= 1'b0;
            col_prev_reg <= 1'b0;
            key_reg      <= 4'd0;
            scans_reg    <= 8'd0;
`ifdef KEYPAD_EMU_BOUNCE_EN
            timer_reg    <= '0;
            edges_reg    <= '0;
`endif
        end else begin
            col_prev_reg <= col_hit;
            case (state_reg)
                IDLE: begin
                    if (press_req) begin
                        key_reg      <= key_id;
                        scans_reg    <= 8'd0;
                        // Seed the edge detector from the new column so a level
                        // already high on entry is not counted as a scan.
                        col_prev_reg <= col[key_id[1:0]];
                        contact_reg  <= 1'b1;
                        busy_reg     <= 1'b1;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state_reg    <= PRESS_BOUNCE;
                        held_reg     <= 1'b0;
                        timer_reg    <= '0;
                        edges_reg    <= '0;
`else
                        state_reg    <= HELD;
                        held_reg     <= 1'b1;
`endif
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                PRESS_BOUNCE: begin
                    if (phase_done) begin
                        timer_reg <= '0;
                        if (last_edge) begin
                            edges_reg   <= '0;
                            contact_reg <= 1'b1;
                            state_reg   <= HELD;
                            held_reg    <= 1'b1;
                        end else begin
                            edges_reg   <= edges_reg + 1'b1;
                            contact_reg <= ~contact_reg;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
`endif
                HELD: begin
                    if (scan_edge && scans_reg != 8'hFF) begin
                        scans_reg <= scans_reg + 8'd1;
                    end
                    if (release_req) begin
                        contact_reg <= 1'b0;
                        held_reg    <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
                        state_reg   <= RELEASE_BOUNCE;
                        timer_reg   <= '0;
                        edges_reg   <= '0;
`else
                        state_reg   <= IDLE;
                        busy_reg    <= 1'b0;
`endif
                    end
                end
`ifdef KEYPAD_EMU_BOUNCE_EN
                RELEASE_BOUNCE: begin
                    if (phase_done) begin
                        timer_reg <= '0;
                        if (last_edge) begin
                            edges_reg   <= '0;
                            contact_reg <= 1'b0;
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                        end else begin
                            edges_reg   <= edges_reg + 1'b1;
                            contact_reg <= ~contact_reg;
                        end
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
`endif
                default: begin
                    state_reg   <= IDLE;
                    contact_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    held_reg    <= 1'b0;
                end
            endcase
        end
    end

    // Row return: only the latched row can assert, gated by contact and the latched column.
    always_comb begin
        fila = 4'b0000;
        if (contact_reg && col_hit && !rst) begin
            fila[key_reg[3:2]] = 1'b1;
        end
    end

    // Status outputs are forced low while reset is applied.
    assign busy  = busy_reg & ~rst;
    assign held  = held_reg & ~rst;
    assign scans = scans_reg;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Testbench for keypad_matrix_emulator (BOUNCE_CYCLES=4, BOUNCE_EDGES=3).
// A behavioural model tracks the press/hold/release timeline arithmetically and
// is compared with the DUT on every falling edge; directed scenarios add
// hand-computed literal expectations. Follows KEYPAD_EMU_BOUNCE_EN if defined.
module tb_keypad_matrix_emulator;

    localparam int BC = 4;
    localparam int BE = 3;
`ifdef KEYPAD_EMU_BOUNCE_EN
    localparam bit BOUNCE_ON = 1'b1;
`else
    localparam bit BOUNCE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] col = 4'b0000;
    logic [3:0] key_id = 4'd0;
    logic       press_req = 1'b0;
    logic       release_req = 1'b0;
    logic [3:0] fila;
    logic       busy;
    logic       held;
    logic [7:0] scans;

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    keypad_matrix_emulator #(
        .BOUNCE_CYCLES(BC),
        .BOUNCE_EDGES (BE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .col        (col),
        .fila       (fila),
        .key_id     (key_id),
        .press_req  (press_req),
        .release_req(release_req),
        .busy       (busy),
        .held       (held),
        .scans      (scans)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_state: 0 idle, 1 press burst, 2 held, 3 release burst
    int         m_state = 0;
    int         m_el = 0;       // clocks elapsed since the burst began
    logic [3:0] m_key = 4'd0;
    int         m_scans = 0;
    logic       m_prev = 1'b0;

    always @(posedge clk) begin
        logic cur;
        logic nprev;
        if (rst) begin
            m_state = 0; m_el = 0; m_key = 4'd0; m_scans = 0; m_prev = 1'b0;
        end else begin
            cur   = col[m_key[1:0]];
            nprev = cur;
            case (m_state)
                0: if (press_req) begin
                    m_key   = key_id;
                    m_scans = 0;
                    nprev   = col[key_id[1:0]];
                    m_el    = 0;
                    m_state = BOUNCE_ON ? 1 : 2;
                end
                1: begin
                    m_el++;
                    if (m_el == BC * BE) m_state = 2;
                end
                2: begin
                    if (cur && !m_prev && m_scans < 255) m_scans++;
                    if (release_req) begin
                        m_el    = 0;
                        m_state = BOUNCE_ON ? 3 : 0;
                    end
                end
                default: begin
                    m_el++;
                    if (m_el == BC * BE) m_state = 0;
                end
            endcase
            m_prev = nprev;
        end
    end

    function automatic logic model_contact();
        case (m_state)
            1:       return ((m_el / BC) % 2) == 0;
            2:       return 1'b1;
            3:       return ((m_el / BC) % 2) != 0;
            default: return 1'b0;
        endcase
    endfunction

    always @(negedge clk) begin
        logic [3:0] exp_fila;
        if (check_en) begin
            exp_fila = 4'b0000;
            if (model_contact() && col[m_key[1:0]] && !rst) exp_fila = 4'b0001 << m_key[3:2];
            check("model_fila", fila, exp_fila);
            check("model_busy", busy, !rst && m_state != 0);
            check("model_held", held, !rst && m_state == 2);
            check("model_scans", scans, m_scans);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic press(input logic [3:0] k);
        $display("press key %0d, col=%b", k, col);
        key_id    = k;
        press_req = 1'b1;
        step();
        press_req = 1'b0;
        key_id    = ~k;
    endtask

    task automatic release_key();
        $display("release, scans=%0d", scans);
        release_req = 1'b1;
        step();
        release_req = 1'b0;
    endtask

    task automatic wait_held();
        int n = 0;
        while (!held && n < 100) begin step(); n++; end
        check("wait_held", held, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin step(); n++; end
        check("wait_idle", busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] bounce_seq;
        bounce_seq = 12'b1111_0000_1111;   // fila[1] per clock during the press burst

        // Reset state with all columns driven
        col = 4'b1111;
        step();
        check_en = 1'b1;
        $display("reset applied");
        check("rst_busy", busy, 1'b0);
        check("rst_held", held, 1'b0);
        check("rst_fila", fila, 4'b0000);
        check("rst_scans", scans, 8'd0);
        rst = 1'b0;
        step();

        // Release in IDLE is ignored
        $display("release_req in IDLE");
        release_req = 1'b1; step(); release_req = 1'b0;
        check("idle_release_busy", busy, 1'b0);

        // Press key 6 with its column driven: bounce pattern, then held
        col = 4'b0100;
        press(4'd6);
`ifdef KEYPAD_EMU_BOUNCE_EN
        for (int i = 0; i < 12; i++) begin
            check($sformatf("bounce_fila_%0d", i), fila, bounce_seq[11 - i] ? 4'b0010 : 4'b0000);
            check($sformatf("bounce_held_%0d", i), held, 1'b0);
            step();
        end
`endif
        check("press6_held", held, 1'b1);
        check("press6_fila", fila, 4'b0010);

        // Ten full one-hot column rotations
        $display("rotate col over 10 scans");
        for (int s = 0; s < 10; s++) begin
            for (int c = 0; c < 4; c++) begin
                col = 4'b0001 << c;
                #1;
                check("rot_fila", fila, (c == 2) ? 4'b0010 : 4'b0000);
                step();
            end
        end
        check("rot_scans", scans, 8'd10);
        release_key();
        wait_idle();
        col = 4'b0100;
        #1;
        check("rel6_fila", fila, 4'b0000);
        check("rel6_scans", scans, 8'd10);

        // Press during bounce is ignored; simultaneous press/release in HELD releases
        col = 4'b0010;
        press(4'd5);
        step(); step();
        $display("press_req key 9 during press bounce");
        key_id = 4'd9; press_req = 1'b1; step(); press_req = 1'b0;
        wait_held();
        check("key5_fila", fila, 4'b0010);
        $display("press_req and release_req together in HELD");
        key_id = 4'd2; press_req = 1'b1; release_req = 1'b1;
        step();
        press_req = 1'b0; release_req = 1'b0;
        check("both_held", held, 1'b0);
        check("both_busy", busy, BOUNCE_ON);
        wait_idle();

        // Saturation: key 15, 300 scans
        col = 4'b0000;
        press(4'd15);
        wait_held();
        $display("drive 300 scans on col[3]");
        for (int s = 0; s < 300; s++) begin
            col = 4'b1000; step();
            col = 4'b0000; step();
        end
        check("sat_scans", scans, 8'd255);
        col = 4'b1000;
        release_key();
        wait_idle();
        check("sat_rel_scans", scans, 8'd255);
        check("sat_rel_fila", fila, 4'b0000);
        check("sat_rel_busy", busy, 1'b0);

        // Reset mid press burst
        col = 4'b1111;
        press(4'd0);
        step(); step(); step(); step();
        $display("reset pulse mid operation");
        rst = 1'b1; step(); rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_held", held, 1'b0);
        check("abort_fila", fila, 4'b0000);
        check("abort_scans", scans, 8'd0);
        press(4'd0);
        wait_held();
        check("key0_fila", fila, 4'b0001);
        for (int s = 0; s < 3; s++) begin
            col = 4'b1110; step();
            col = 4'b1111; step();
        end
        check("key0_scans", scans, 8'd3);
        $display("reset pulse in HELD");
        rst = 1'b1; step(); rst = 1'b0;
        check("abort2_scans", scans, 8'd0);
        check("abort2_held", held, 1'b0);
        step();

`ifndef KEYPAD_EMU_BOUNCE_EN
        // Bounce-free build: single-clock press and release of key 3
        col = 4'b1000;
        press(4'd3);
        check("nb_held", held, 1'b1);
        check("nb_fila", fila, 4'b0001);
        release_key();
        check("nb_rel_fila", fila, 4'b0000);
        check("nb_rel_busy", busy, 1'b0);
`endif
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_emulator.md
KEYPAD_MATRIX_EMULATOR -- requirements
Module: keypad_matrix_emulator

Interface
REQ-001 The block SHALL have parameter BOUNCE_CYCLES, default 8, meaning clocks per contact-bounce phase (legal range 1 to 255).
REQ-002 The block SHALL have parameter BOUNCE_EDGES, default 4, meaning contact toggles per bounce burst (legal range 1 to 15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port col, input, 4 bits: column drive from the keypad scanner; active-high, one-hot when legal.
REQ-006 The block SHALL have port fila, output, 4 bits: row return to the keypad scanner; active-high.
REQ-007 The block SHALL have port key_id, input, 4 bits: key to press; row = key_id[3:2], column = key_id[1:0], so the index runs 0 to 15.
REQ-008 The block SHALL have port press_req, input, 1 bit: single-cycle request to press key_id.
REQ-009 The block SHALL have port release_req, input, 1 bit: single-cycle request to release the held key.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-011 The block SHALL have port held, output, 1 bit: high only in state HELD.
REQ-012 The block SHALL have port scans, output, 8 bits: count of completed scans of the key column while in HELD.

Function
REQ-013 The block SHALL implement states IDLE, PRESS_BOUNCE, HELD and RELEASE_BOUNCE.
REQ-014 In IDLE, press_req=1 SHALL latch key_id, clear scans to 0, and move to PRESS_BOUNCE on the next edge.
REQ-015 Later changes on key_id SHALL be ignored until the block returns to IDLE.
REQ-016 The block SHALL hold an internal registered contact bit.
REQ-017 Contact SHALL be 0 in IDLE and 1 in HELD.
REQ-018 In PRESS_BOUNCE, contact SHALL start at 1 and toggle every BOUNCE_CYCLES clocks, BOUNCE_EDGES times in total.
REQ-019 After the final toggle of PRESS_BOUNCE, contact SHALL be forced to 1 and the state SHALL become HELD on the same edge.
REQ-020 In HELD, release_req=1 SHALL move the block to RELEASE_BOUNCE.
REQ-021 In RELEASE_BOUNCE, contact SHALL start at 0 and toggle as in PRESS_BOUNCE.
REQ-022 After the final toggle of RELEASE_BOUNCE, contact SHALL be forced to 0 and the state SHALL become IDLE.
REQ-023 fila SHALL be combinational from col: fila[row] = contact AND col[column], and every other fila bit SHALL be 0.
REQ-024 Multiple col bits high SHALL have no effect beyond REQ-023, because only the latched column is examined.
REQ-025 scans SHALL increment on each 0-to-1 transition of col[column] sampled in HELD.
REQ-026 scans SHALL saturate at 255 and hold its value outside HELD until the next accepted press.
REQ-027 A col[column] edge that coincides with the edge entering HELD SHALL NOT be counted.
REQ-028 The block SHALL ignore press_req outside IDLE and ignore release_req outside HELD.
REQ-029 If press_req and release_req are both high in IDLE, the press SHALL win.
REQ-030 If press_req and release_req are both high in HELD, the release SHALL win.
REQ-031 The bounce timers SHALL be sized from the parameters, and no counter SHALL wrap.

Reset
REQ-032 Reset SHALL put the state in IDLE and set contact=0, scans=0, latched key=0 and timers=0.
REQ-033 Under reset, busy=0, held=0 and fila=4'b0000 SHALL hold regardless of col.
REQ-034 rst asserted mid-bounce or in HELD SHALL abort the operation on that edge, and the next press SHALL restart cleanly.

Configuration
REQ-035 With macro KEYPAD_EMU_BOUNCE_EN defined, the bounce states SHALL behave as in REQ-018 to REQ-022.
REQ-036 Without KEYPAD_EMU_BOUNCE_EN, the bounce states SHALL be skipped: IDLE goes to HELD, and HELD goes to IDLE, one clock after the request, with contact stepping once.
REQ-037 Without KEYPAD_EMU_BOUNCE_EN, the bounce counters SHALL NOT be synthesised, and the parameters SHALL be accepted but unused.

Verification (BOUNCE_CYCLES=4, BOUNCE_EDGES=3, KEYPAD_EMU_BOUNCE_EN defined unless stated)
REQ-038 Press key_id=6 with col held at 4'b0100 -> fila[1] follows 1,0,1 for 4 clocks each, then stays 1; held=1 12 clocks after entry; fila[0], fila[2] and fila[3] stay 0.
REQ-039 In HELD with key 6, rotate col one-hot over 10 full scans -> fila=4'b0010 only while col=4'b0100, fila=0 otherwise; scans=10.
REQ-040 Press key 15, drive 300 col scans, then release -> scans=255 (saturates); after the release burst fila=0, busy=0, and scans still reads 255.
REQ-041 Send press_req during PRESS_BOUNCE, release_req in IDLE, and a simultaneous press/release in HELD -> the first two are ignored, and the third starts RELEASE_BOUNCE.
REQ-042 Assert rst for 1 clock in mid PRESS_BOUNCE with col=4'b1111 -> the next edge gives IDLE, fila=0 and scans=0; a following press of key 0 completes normally.
REQ-043 With KEYPAD_EMU_BOUNCE_EN undefined, press key 3 -> held=1 and fila[0]=col[3] one clock later; release -> fila=0 and busy=0 one clock later.
